// File: rtl/file_mem_pkg.sv
// Shared types and constants for the file-memory burst adapter.
package file_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    WACK
  } state_e;

  localparam int unsigned RESP_FIFO_DEPTH = 2;
  localparam int unsigned RESP_CNT_BITS   = $clog2(RESP_FIFO_DEPTH + 1);
  localparam int unsigned RESP_PTR_BITS   = (RESP_FIFO_DEPTH > 1) ? $clog2(RESP_FIFO_DEPTH) : 1;

endpackage

// File: rtl/file_mem_resp_fifo.sv
// Small response FIFO holding read beats (data + last flag) until the
// upstream read channel accepts them.
module file_mem_resp_fifo
  import file_mem_pkg::*;
#(
  parameter int unsigned DATA_BITS = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [DATA_BITS-1:0]     push_data_i,
  input  logic                     push_last_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [DATA_BITS-1:0]     data_o,
  output logic                     last_o,
  output logic [RESP_CNT_BITS-1:0] count_o
);

  logic [DATA_BITS-1:0]     data_q [RESP_FIFO_DEPTH];
  logic                     last_q [RESP_FIFO_DEPTH];
  logic [RESP_PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [RESP_PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [RESP_CNT_BITS-1:0] count_q, count_d;

  function automatic logic [RESP_PTR_BITS-1:0] ptr_inc(input logic [RESP_PTR_BITS-1:0] p);
    return (p == RESP_PTR_BITS'(RESP_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push_i && !pop_i)      count_d = count_q + 1'b1;
    else if (!push_i && pop_i) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < RESP_FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push_i) begin
        data_q[wr_ptr_q] <= push_data_i;
        last_q[wr_ptr_q] <= push_last_i;
      end
    end
  end

  // Outputs are forced to zero while empty so stale entries never leak out.
  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? data_q[rd_ptr_q] : '0;
  assign last_o  = valid_o ? last_q[rd_ptr_q] : 1'b0;
  assign count_o = count_q;

endmodule

// File: rtl/file_mem_burst_adapter.sv
// Converts burst read/write commands into single-beat accesses on a
// file-memory port that performs an access every clock.
module file_mem_burst_adapter
  import file_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 64,
  parameter int unsigned LEN_BITS  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [LEN_BITS-1:0]  req_len,
  input  logic                 req_write,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  input  logic [DATA_BITS-1:0] wdata,
  output logic                 rdata_valid,
  input  logic                 rdata_ready,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 rdata_last,
  output logic                 wack_valid,
  input  logic                 wack_ready,
  output logic                 mem_req_valid,
  output logic [ADDR_BITS-1:0] mem_req_addr,
  output logic [DATA_BITS-1:0] mem_req_data,
  output logic                 mem_req_r_wb,
  input  logic [DATA_BITS-1:0] mem_resp_data
);

  localparam logic [ADDR_BITS-1:0] ADDR_STEP = ADDR_BITS'(DATA_BITS / 8);

  state_e                   state_q, state_d;
  logic [ADDR_BITS-1:0]     addr_q, addr_d;
  logic [LEN_BITS-1:0]      len_q, len_d;
  logic [LEN_BITS-1:0]      beat_q, beat_d;
  logic                     issued_all_q, issued_all_d;
  logic                     inflight_q, inflight_d;
  logic                     inflight_last_q, inflight_last_d;

  logic                     fifo_valid;
  logic [RESP_CNT_BITS-1:0] fifo_count;
  logic                     rd_pop;
  logic                     rd_issue;
  logic                     wr_beat;
  logic [RESP_CNT_BITS:0]   occupancy;

  assign rd_pop = fifo_valid && rdata_ready;
  // A pop in the same cycle frees a slot, which is what sustains 1 beat/cycle.
  assign occupancy = (RESP_CNT_BITS+1)'(fifo_count) + (RESP_CNT_BITS+1)'(inflight_q)
                   - (RESP_CNT_BITS+1)'(rd_pop);
  assign rd_issue  = (state_q == READ) && !issued_all_q
                   && (occupancy < (RESP_CNT_BITS+1)'(RESP_FIFO_DEPTH));
  assign wr_beat   = (state_q == WRITE) && wdata_valid;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      beat_q          <= '0;
      issued_all_q    <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      beat_q          <= beat_d;
      issued_all_q    <= issued_all_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    len_d           = len_q;
    beat_d          = beat_q;
    issued_all_d    = issued_all_q;
    inflight_d      = rd_issue;
    inflight_last_d = rd_issue && (beat_q == len_q);
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d       = req_addr;
          len_d        = req_len;
          beat_d       = '0;
          issued_all_d = 1'b0;
          state_d      = req_write ? WRITE : READ;
        end
      end
      READ: begin
        if (rd_issue) begin
          addr_d = addr_q + ADDR_STEP;
          beat_d = beat_q + 1'b1;
          if (beat_q == len_q) issued_all_d = 1'b1;
        end
        if (rd_pop && rdata_last) state_d = IDLE;
      end
      WRITE: begin
        if (wr_beat) begin
          addr_d = addr_q + ADDR_STEP;
          beat_d = beat_q + 1'b1;
          if (beat_q == len_q) state_d = WACK;
        end
      end
      WACK: begin
        if (wack_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == IDLE);
    wdata_ready   = (state_q == WRITE);
    wack_valid    = (state_q == WACK);
    mem_req_valid = rd_issue || wr_beat;
    mem_req_r_wb  = !wr_beat;
    mem_req_addr  = (rd_issue || wr_beat) ? addr_q : '0;
    mem_req_data  = wr_beat ? wdata : '0;
  end

  file_mem_resp_fifo #(
    .DATA_BITS(DATA_BITS)
  ) u_resp_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (inflight_q),
    .push_data_i(mem_resp_data),
    .push_last_i(inflight_last_q),
    .pop_i      (rd_pop),
    .valid_o    (fifo_valid),
    .data_o     (rdata),
    .last_o     (rdata_last),
    .count_o    (fifo_count)
  );

  assign rdata_valid = fifo_valid;

endmodule

// File: tb/tb_file_mem_burst_adapter.sv
// Directed scoreboard bench for file_mem_burst_adapter with a one-cycle
// latency memory model.
module tb_file_mem_burst_adapter;

  localparam int unsigned AB = 32;
  localparam int unsigned DB = 64;
  localparam int unsigned LB = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AB-1:0] req_addr = '0;
  logic [LB-1:0] req_len = '0;
  logic          req_write = 1'b0;
  logic          wdata_valid = 1'b0;
  logic          wdata_ready;
  logic [DB-1:0] wdata = '0;
  logic          rdata_valid;
  logic          rdata_ready = 1'b0;
  logic [DB-1:0] rdata;
  logic          rdata_last;
  logic          wack_valid;
  logic          wack_ready = 1'b0;
  logic          mem_req_valid;
  logic [AB-1:0] mem_req_addr;
  logic [DB-1:0] mem_req_data;
  logic          mem_req_r_wb;
  logic [DB-1:0] mem_resp_data = '0;

  int checks = 0;
  int errors = 0;
  int n_iss = 0;
  int n_rd = 0;
  int n_wr = 0;
  bit acc;

  logic [AB-1:0]    exp_iss[$];
  logic [DB:0]      exp_rd[$];
  logic [AB+DB-1:0] exp_wr[$];

  always #5 clock = ~clock;

  file_mem_burst_adapter #(
    .ADDR_BITS(AB),
    .DATA_BITS(DB),
    .LEN_BITS (LB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .req_write    (req_write),
    .wdata_valid  (wdata_valid),
    .wdata_ready  (wdata_ready),
    .wdata        (wdata),
    .rdata_valid  (rdata_valid),
    .rdata_ready  (rdata_ready),
    .rdata        (rdata),
    .rdata_last   (rdata_last),
    .wack_valid   (wack_valid),
    .wack_ready   (wack_ready),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr (mem_req_addr),
    .mem_req_data (mem_req_data),
    .mem_req_r_wb (mem_req_r_wb),
    .mem_resp_data(mem_resp_data)
  );

  function automatic logic [DB-1:0] mem_fn(input logic [AB-1:0] a);
    return {a ^ 32'h5EED_C0DE, a};
  endfunction

  // Memory answers a read in the cycle after it was issued; otherwise garbage.
  always @(posedge clock)
    mem_resp_data <= (mem_req_valid && mem_req_r_wb) ? mem_fn(mem_req_addr) : 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_nonempty(input string tag, input int sz);
    checks++;
    assert (sz > 0) else begin
      errors++;
      $error("FAIL %s observed=unexpected_transfer expected=none", tag);
    end
  endtask

  task automatic step();
    @(negedge clock);
    if (mem_req_valid && mem_req_r_wb) begin
      n_iss++;
      chk_nonempty("rd_issue", exp_iss.size());
      if (exp_iss.size() > 0) chk("rd_issue_addr", mem_req_addr, exp_iss.pop_front());
    end
    if (mem_req_valid && !mem_req_r_wb) begin
      n_wr++;
      chk_nonempty("wr_issue", exp_wr.size());
      if (exp_wr.size() > 0) chk("wr_issue_addr_data", {mem_req_addr, mem_req_data}, exp_wr.pop_front());
    end else begin
      chk("no_wr_rwb_data", {mem_req_r_wb, mem_req_data}, {1'b1, 64'h0});
    end
    if (rdata_valid && rdata_ready) begin
      n_rd++;
      chk_nonempty("rdata_xfer", exp_rd.size());
      if (exp_rd.size() > 0) chk("rdata_last_data", {rdata_last, rdata}, exp_rd.pop_front());
    end
    acc = req_valid && req_ready;
    @(posedge clock);
    #1;
  endtask

  task automatic exp_read(input logic [AB-1:0] addr, input int len);
    logic [AB-1:0] a;
    for (int b = 0; b <= len; b++) begin
      a = addr + AB'(b * (DB / 8));
      exp_iss.push_back(a);
      exp_rd.push_back({(b == len), mem_fn(a)});
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [AB-1:0] addr, input logic [LB-1:0] len);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_len   = len;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) step();
    chk("cmd_accept", acc, 1);
    req_valid = 1'b0;
  endtask

  task automatic wait_rd(input int n, input int budget);
    for (int i = 0; i < budget && n_rd < n; i++) step();
    chk("rd_beats", n_rd, n);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk(tag, {req_ready, wdata_ready, rdata_valid, rdata_last, wack_valid, mem_req_valid, mem_req_r_wb},
        7'b1000001);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_addr_data"}, {mem_req_addr, mem_req_data}, 0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk_reset_outs("reset");
    reset = 1'b1;
    step();

    // Back-to-back read, full throughput.
    rdata_ready = 1'b1;
    n_iss = 0; n_rd = 0;
    exp_read(32'h100, 3);
    send_cmd(1'b0, 32'h100, 8'd3);
    repeat (4) step();
    chk("rd_consecutive_issues", n_iss, 4);
    chk("rd_throughput", n_rd, 2);
    wait_rd(4, 10);
    chk("rd_back_idle", req_ready, 1);
    chk("rd_sb_empty", exp_rd.size(), 0);

    // Same read, consumer stalled.
    rdata_ready = 1'b0;
    n_iss = 0; n_rd = 0;
    exp_read(32'h100, 3);
    send_cmd(1'b0, 32'h100, 8'd3);
    repeat (5) step();
    chk("stall_issue_cnt", n_iss, 2);
    chk("stall_no_rd", n_rd, 0);
    chk("stall_head", {rdata_valid, rdata}, {1'b1, mem_fn(32'h100)});
    rdata_ready = 1'b1;
    wait_rd(4, 20);
    chk("stall_total_issues", n_iss, 4);
    chk("stall_sb_empty", exp_rd.size() + exp_iss.size(), 0);
    chk("stall_back_idle", req_ready, 1);

    // Two-beat write and completion handshake.
    n_wr = 0;
    exp_wr.push_back({32'h40, 64'hA5});
    exp_wr.push_back({32'h48, 64'h5A});
    send_cmd(1'b1, 32'h40, 8'd1);
    chk("wr_wdata_ready", wdata_ready, 1);
    wdata_valid = 1'b1;
    wdata = 64'hA5;
    step();
    wdata = 64'h5A;
    step();
    wdata_valid = 1'b0;
    chk("wr_beats", n_wr, 2);
    chk("wack_set", {wack_valid, wdata_ready}, 2'b10);
    repeat (3) begin
      step();
      chk("wack_hold", {wack_valid, req_ready}, 2'b10);
    end
    wack_ready = 1'b1;
    step();
    wack_ready = 1'b0;
    chk("wack_done", {wack_valid, req_ready}, 2'b01);

    // Address wrap-around.
    n_rd = 0;
    exp_read(32'hFFFF_FFF8, 1);
    send_cmd(1'b0, 32'hFFFF_FFF8, 8'd1);
    wait_rd(2, 20);

    // Single-beat and maximum-length bursts.
    n_rd = 0;
    exp_read(32'h2000, 0);
    send_cmd(1'b0, 32'h2000, 8'd0);
    wait_rd(1, 10);
    chk("len0_idle", req_ready, 1);
    n_rd = 0; n_iss = 0;
    exp_read(32'h1000, 255);
    send_cmd(1'b0, 32'h1000, 8'd255);
    wait_rd(256, 400);
    chk("lenmax_issues", n_iss, 256);
    chk("lenmax_idle", req_ready, 1);

    // Reset in the middle of a read burst.
    exp_read(32'h300, 7);
    send_cmd(1'b0, 32'h300, 8'd7);
    step();
    step();
    reset = 1'b0;
    step();
    chk_reset_outs("midreset");
    exp_iss.delete();
    exp_rd.delete();
    reset = 1'b1;
    step();
    chk("post_reset_no_data", rdata_valid, 0);
    n_rd = 0;
    exp_read(32'h500, 0);
    send_cmd(1'b0, 32'h500, 8'd0);
    wait_rd(1, 10);
    chk("post_reset_sb_empty", exp_rd.size(), 0);

    // Idle: no accesses other than implicit reads.
    n_iss = 0; n_wr = 0;
    repeat (100) step();
    chk("idle_no_write", n_wr, 0);
    chk("idle_no_issue", n_iss, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/file_mem_burst_adapter.md
FILE_MEM_BURST_ADAPTER -- requirements
Module: file_mem_burst_adapter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 32: byte-address width, at most 64.
REQ-002 SHALL have parameter DATA_BITS, default 64: beat width, one of 8/16/32/64.
REQ-003 SHALL have parameter LEN_BITS, default 8: width of the burst length field.
REQ-004 SHALL have port clock  in  1  clock; all logic rising-edge.
REQ-005 SHALL have port reset  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports req_valid in 1, req_ready out 1, req_addr in ADDR_BITS, req_len in LEN_BITS (beats-1), req_write in 1: burst command channel.
REQ-007 SHALL have ports wdata_valid in 1, wdata_ready out 1, wdata in DATA_BITS: write beat channel.
REQ-008 SHALL have ports rdata_valid out 1, rdata_ready in 1, rdata out DATA_BITS, rdata_last out 1: read beat channel.
REQ-009 SHALL have ports wack_valid out 1, wack_ready in 1: write-burst completion channel.
REQ-010 SHALL have ports mem_req_valid out 1, mem_req_addr out ADDR_BITS, mem_req_data out DATA_BITS, mem_req_r_wb out 1, mem_resp_data in DATA_BITS: downstream file-memory port.

Function
REQ-011 All ready/valid channels SHALL transfer on valid&&ready at a rising edge; an asserted valid and its payload SHALL hold until the transfer.
REQ-012 FSM states SHALL be IDLE, READ, WRITE, WACK; req_ready=1 only in IDLE.
REQ-013 A command transfer SHALL latch addr, len and beat counter=0, and move to READ if req_write=0, otherwise WRITE.
REQ-014 Beat n address SHALL be req_addr + n*(DATA_BITS/8), truncated modulo 2^ADDR_BITS (wrap-around, no error).
REQ-015 The memory performs an access on every clock, so mem_req_r_wb SHALL be 1 in every cycle without a write beat issue; mem_req_data SHALL then be 0.
REQ-016 READ: one read beat SHALL issue per cycle (mem_req_valid=1, r_wb=1) only while response FIFO occupancy plus in-flight reads is below 2.
REQ-017 mem_resp_data SHALL be captured into the 2-entry response FIFO exactly one cycle after its issue cycle; rdata_last SHALL mark beat len.
REQ-018 READ SHALL return to IDLE in the cycle the last beat (rdata_last=1) transfers on the rdata channel.
REQ-019 WRITE: wdata_ready SHALL be 1 in WRITE, and each wdata transfer SHALL issue mem_req_valid=1, r_wb=0, data=wdata in the same cycle (zero latency).
REQ-020 After write beat len, state SHALL become WACK with wack_valid=1, held until wack_ready, then IDLE.
REQ-021 Back-to-back read throughput SHALL be 1 beat/cycle when rdata_ready is held 1.
REQ-022 Simultaneous FIFO push and pop SHALL keep occupancy unchanged; a push SHALL never occur into a full FIFO.
REQ-023 req_len=0 SHALL produce a single-beat burst; req_len=2^LEN_BITS-1 SHALL produce 2^LEN_BITS beats.

Reset
REQ-024 With reset low at a clock edge: state=IDLE, counters=0, FIFO empty, in-flight cleared.
REQ-025 Outputs during and after reset: req_ready=1, wdata_ready=0, rdata_valid=0, rdata_last=0, rdata=0, wack_valid=0, mem_req_valid=0, mem_req_r_wb=1, mem_req_addr=0, mem_req_data=0.
REQ-026 Reset mid-burst SHALL abandon the burst; a read response arriving after reset SHALL be discarded.

Structure
REQ-027 Package file_mem_pkg SHALL hold the FSM state enum and the response FIFO depth constant (2).
REQ-028 Sub-module file_mem_resp_fifo SHALL implement the 2-entry data+last FIFO with count output.

Verification
REQ-029 Read addr=0x100, len=3, rdata_ready=1 -> mem addrs 0x100/0x108/0x110/0x118 on consecutive cycles; 4 rdata beats, last on 4th.
REQ-030 Same read with rdata_ready=0 for 5 cycles -> exactly 2 issues, stall, then no data lost or duplicated.
REQ-031 Write addr=0x40, len=1, data 0xA5,0x5A -> two r_wb=0 cycles at 0x40/0x48, then wack_valid until wack_ready.
REQ-032 Read addr=0xFFFFFFF8, len=1 -> second beat address 0x00000000.
REQ-033 Reset asserted during beat 2 of len=7 read -> REQ-025 values next cycle; subsequent read len=0 returns one correct beat.
REQ-034 Idle 100 cycles -> mem_req_r_wb=1 every cycle, no write issued.
